dual_filter_mac_ctrl: RTL and testbench

Sequencer for the packed dual-filter DSP multiplier. The multiplier computes two signed 8x8 products per cycle that share one activation operand: in_1*in_3 on out1 and in_2*in_3 on out2. This block pairs an activation stream with a weight-pair stream and issues one tap per cycle to the multiplier. It tracks products through the fixed multiplier latency, accumulates both filters over a configured tap count (e.g. 3x3xC), and presents the two sums on a valid/ready result port.

---
 rtl/dual_filter_mac_ctrl_if.sv | 41 ++++
 rtl/dual_filter_mac_ctrl.sv | 112 +++++++++++
 tb/tb_dual_filter_mac_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dual_filter_mac_ctrl_if.sv
// Stream, multiplier and result signals of the dual-filter MAC sequencer.
// The master side is the sequencer; the slave side is its environment.
interface dual_filter_mac_ctrl_if #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 12
);
   logic             start;
   logic [CNT_W-1:0] cfg_taps;
   logic             busy;
   logic             done;
   logic             act_valid;
   logic             act_ready;
   logic [7:0]       act_data;
   logic             wgt_valid;
   logic             wgt_ready;
   logic [7:0]       wgt_a;
   logic [7:0]       wgt_b;
   logic [7:0]       dsp_in_1;
   logic [7:0]       dsp_in_2;
   logic [7:0]       dsp_in_3;
   logic [15:0]      dsp_out1;
   logic [15:0]      dsp_out2;
   logic             res_valid;
   logic             res_ready;
   logic [ACC_W-1:0] res_a;
   logic [ACC_W-1:0] res_b;

   modport master (
      input  start, cfg_taps, act_valid, act_data, wgt_valid, wgt_a, wgt_b,
             dsp_out1, dsp_out2, res_ready,
      output busy, done, act_ready, wgt_ready, dsp_in_1, dsp_in_2, dsp_in_3,
             res_valid, res_a, res_b
   );

   modport slave (
      output start, cfg_taps, act_valid, act_data, wgt_valid, wgt_a, wgt_b,
             dsp_out1, dsp_out2, res_ready,
      input  busy, done, act_ready, wgt_ready, dsp_in_1, dsp_in_2, dsp_in_3,
             res_valid, res_a, res_b
   );
endinterface

// File: rtl/dual_filter_mac_ctrl.sv
// Pairs activations with weight pairs, issues one tap per cycle to the packed
// dual multiplier and accumulates both filter sums over the configured taps.
module dual_filter_mac_ctrl #(
   parameter int DSP_LAT = 3,
   parameter int ACC_W   = 24,
   parameter int CNT_W   = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dual_filter_mac_ctrl_if.master bus
);
   localparam int NUM_LANES = 2;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_e;

   state_e                             state_q, state_d;
   logic [CNT_W-1:0]                   taps_q, taps_d;
   logic [CNT_W-1:0]                   issued_q, issued_d;
   logic [CNT_W-1:0]                   retired_q, retired_d;
   logic [NUM_LANES-1:0][ACC_W-1:0]    acc_q, acc_d;
   logic [NUM_LANES-1:0][ACC_W-1:0]    res_q, res_d;
   logic [2:0][7:0]                    op_q;
   logic [DSP_LAT:0]                   vld_pipe;
   logic [NUM_LANES-1:0][15:0]         prod;
   logic                               fire;
   logic                               pop;

   assign prod = {bus.dsp_out2, bus.dsp_out1};
   assign fire = (state_q == S_RUN) & bus.act_valid & bus.wgt_valid & (issued_q < taps_q);
   // Top bit of the valid pipe lines up with the products on dsp_out1/2.
   assign pop  = vld_pipe[DSP_LAT];

   assign bus.act_ready = fire;
   assign bus.wgt_ready = fire;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.res_valid = (state_q == S_OUT);
   assign bus.done      = (state_q == S_OUT) & bus.res_ready;
   assign bus.dsp_in_1  = op_q[0];
   assign bus.dsp_in_2  = op_q[1];
   assign bus.dsp_in_3  = op_q[2];
   assign bus.res_a     = res_q[0];
   assign bus.res_b     = res_q[1];

   always_comb begin
      state_d   = state_q;
      taps_d    = taps_q;
      issued_d  = issued_q;
      retired_d = retired_q;
      acc_d     = acc_q;
      res_d     = res_q;

      if (pop) begin
         for (int l = 0; l < NUM_LANES; l++)
            acc_d[l] = acc_q[l] + ACC_W'($signed(prod[l]));
         retired_d = retired_q + CNT_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               taps_d    = bus.cfg_taps;
               issued_d  = '0;
               retired_d = '0;
               acc_d     = '0;
               if (bus.cfg_taps == '0) begin
                  res_d   = '0;
                  state_d = S_OUT;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (fire) issued_d = issued_q + CNT_W'(1);
            if (issued_d == taps_q) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (retired_d == taps_q) begin
               res_d   = acc_d;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (bus.res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         taps_q    <= '0;
         issued_q  <= '0;
         retired_q <= '0;
         acc_q     <= '0;
         res_q     <= '0;
         op_q      <= '0;
         vld_pipe  <= '0;
      end else begin
         state_q   <= state_d;
         taps_q    <= taps_d;
         issued_q  <= issued_d;
         retired_q <= retired_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
         // Bubbles feed zero operands so a stray product can never be nonzero.
         op_q      <= fire ? {bus.act_data, bus.wgt_b, bus.wgt_a} : '0;
         vld_pipe  <= {vld_pipe[DSP_LAT-1:0], fire};
      end
   end
endmodule

// File: tb/tb_dual_filter_mac_ctrl.sv
// Directed bench for dual_filter_mac_ctrl with a behavioural packed multiplier.
module tb_dual_filter_mac_ctrl;
   localparam int DSP_LAT = 3;
   localparam int ACC_W   = 24;
   localparam int CNT_W   = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dual_filter_mac_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   dual_filter_mac_ctrl #(.DSP_LAT(DSP_LAT), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Multiplier model: products appear DSP_LAT cycles after the operands.
   logic signed [15:0] pa [DSP_LAT];
   logic signed [15:0] pb [DSP_LAT];
   always @(posedge clk) begin
      pa[0] <= $signed(bus.dsp_in_1) * $signed(bus.dsp_in_3);
      pb[0] <= $signed(bus.dsp_in_2) * $signed(bus.dsp_in_3);
      for (int k = 1; k < DSP_LAT; k++) begin
         pa[k] <= pa[k-1];
         pb[k] <= pb[k-1];
      end
   end
   assign bus.dsp_out1 = pa[DSP_LAT-1];
   assign bus.dsp_out2 = pb[DSP_LAT-1];

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   always @(negedge clk) if (bus.done) done_cnt++;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   int qa[$];
   int qwa[$];
   int qwb[$];
   logic [7:0] apat = 8'hFF;
   logic [7:0] wpat = 8'hFF;

   task automatic push(input int n, input int a, input int wa, input int wb);
      repeat (n) begin
         qa.push_back(a);
         qwa.push_back(wa);
         qwb.push_back(wb);
      end
   endtask

   task automatic drive_streams(input int cyc);
      bus.act_valid = (qa.size() > 0) && apat[cyc[2:0]];
      bus.act_data  = (qa.size() > 0) ? 8'(qa[0]) : 8'h0;
      bus.wgt_valid = (qwa.size() > 0) && wpat[cyc[2:0]];
      bus.wgt_a     = (qwa.size() > 0) ? 8'(qwa[0]) : 8'h0;
      bus.wgt_b     = (qwb.size() > 0) ? 8'(qwb[0]) : 8'h0;
   endtask

   // Called at posedge+1. Ends at posedge+1 with the DUT back in IDLE.
   task automatic run_kernel(input string nm, input int taps, input longint ea,
                             input longint eb, input int lat_exp, input int hold,
                             input int rst_after);
      int   cyc = 0;
      int   fired = 0;
      int   rdy_bad = 0;
      int   bad = 0;
      int   d0;
      bit   hs;
      bit   got_rv = 0;
      logic exp_rdy;
      logic [ACC_W-1:0] ra0, rb0;
      d0 = done_cnt;
      bus.start    = 1'b1;
      bus.cfg_taps = CNT_W'(taps);
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.cfg_taps = 12'hABC;
      drive_streams(cyc);
      while (cyc < 2000) begin
         @(negedge clk);
         if (bus.res_valid) begin
            got_rv = 1;
            break;
         end
         exp_rdy = bus.act_valid && bus.wgt_valid && (fired < taps);
         if (bus.act_ready !== exp_rdy || bus.wgt_ready !== exp_rdy) rdy_bad++;
         hs = bus.act_ready;
         @(posedge clk); #1;
         cyc++;
         if (hs) begin
            void'(qa.pop_front());
            void'(qwa.pop_front());
            void'(qwb.pop_front());
            fired++;
            if (rst_after > 0 && fired == rst_after) begin
               #2 rst_n = 1'b0;
               #1;
               chk({nm, "_rst_ctl"}, {bus.busy, bus.done, bus.act_ready, bus.wgt_ready,
                   bus.res_valid, bus.dsp_in_1, bus.dsp_in_2, bus.dsp_in_3}, 0);
               chk({nm, "_rst_res_a"}, longint'(bus.res_a), 0);
               chk({nm, "_rst_res_b"}, longint'(bus.res_b), 0);
               chk({nm, "_rdy"}, rdy_bad, 0);
               qa.delete(); qwa.delete(); qwb.delete();
               drive_streams(0);
               @(posedge clk); #2 rst_n = 1'b1;
               @(posedge clk); #1;
               chk({nm, "_rst_busy"}, bus.busy, 0);
               chk({nm, "_rst_nodone"}, done_cnt - d0, 0);
               return;
            end
         end
         drive_streams(cyc);
      end
      chk({nm, "_res_valid"}, got_rv, 1);
      chk({nm, "_rdy"}, rdy_bad, 0);
      chk({nm, "_fired"}, fired, taps);
      if (lat_exp >= 0) chk({nm, "_lat"}, cyc, lat_exp);
      if (taps == 0) chk({nm, "_lat_le2"}, cyc <= 2, 1);
      chk({nm, "_res_a"}, longint'($signed(bus.res_a)), ea);
      chk({nm, "_res_b"}, longint'($signed(bus.res_b)), eb);
      chk({nm, "_busy"}, bus.busy, 1);
      ra0 = bus.res_a;
      rb0 = bus.res_b;
      // Stall the result port with both streams offering data and a stray start.
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         bus.start     = (h == 5);
         bus.cfg_taps  = 12'd3;
         bus.act_valid = 1'b1;
         bus.wgt_valid = 1'b1;
         @(negedge clk);
         if (bus.res_a !== ra0 || bus.res_b !== rb0 || bus.res_valid !== 1'b1 ||
             bus.act_ready !== 1'b0 || bus.wgt_ready !== 1'b0 || bus.done !== 1'b0) bad++;
      end
      if (hold > 0) chk({nm, "_hold"}, bad, 0);
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.act_valid = 1'b0;
      bus.wgt_valid = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_done"}, bus.done, 1);
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      chk({nm, "_idle"}, {bus.res_valid, bus.busy, bus.done}, 0);
      chk({nm, "_done_once"}, done_cnt - d0, 1);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.cfg_taps  = '0;
      bus.act_valid = 1'b0;
      bus.act_data  = '0;
      bus.wgt_valid = 1'b0;
      bus.wgt_a     = '0;
      bus.wgt_b     = '0;
      bus.res_ready = 1'b0;
      #23;
      chk("reset_ctl", {bus.busy, bus.done, bus.act_ready, bus.wgt_ready, bus.res_valid,
          bus.dsp_in_1, bus.dsp_in_2, bus.dsp_in_3}, 0);
      chk("reset_res", {bus.res_a, bus.res_b}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      push(9, 1, 2, -3);
      run_kernel("basic", 9, 18, -27, 9 + DSP_LAT + 1, 0, 0);

      apat = 8'b1101_0110;
      wpat = 8'b0111_0011;
      push(1, 5, 3, -1);
      push(1, -7, 2, 4);
      push(1, 127, -128, 1);
      push(1, -128, -128, -128);
      run_kernel("bubble", 4, 129, 16478, -1, 20, 0);
      apat = 8'hFF;
      wpat = 8'hFF;

      run_kernel("zero", 0, 0, 0, -1, 0, 0);

      push(511, -128, -128, -128);
      run_kernel("max511", 511, 8372224, 8372224, 511 + DSP_LAT + 1, 0, 0);
      push(512, -128, -128, -128);
      run_kernel("wrap512", 512, -8388608, -8388608, 512 + DSP_LAT + 1, 0, 0);

      push(9, 3, -4, 5);
      run_kernel("abort", 9, 0, 0, -1, 0, 3);
      push(9, 2, 7, -6);
      run_kernel("fresh", 9, 126, -108, 9 + DSP_LAT + 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
